tour_cmd_sequencer: RTL

Synthesizable, parametrised command player that drives the RemoteComm host interface. It is the multi-command successor to the single-move directed bench flow.
- Holds a programmable list of up to DEPTH 16-bit Knight commands.
- Issues them in order and waits for the positive acknowledge after each one.
- Applies a per-opcode timeout and stops with a coded error on a NAK or timeout.
- Used on the bench and on the FPGA host side to run scripted tours without hand-written task sequences.

---
 rtl/tour_pkg.sv | 51 +++++
 rtl/seq_timeout_timer.sv | 55 +++++
 rtl/tour_cmd_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the Knight tour command sequencer.
// The command word layout is opcode / heading / argument nibble.
package tour_pkg;

    localparam logic [3:0] OP_CAL  = 4'h2;
    localparam logic [3:0] OP_MOVE = 4'h4;

    localparam logic [7:0] ACK = 8'hA5;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] arg;
    } knight_cmd_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_NAK     = 2'd1,
        ERR_RESP_TO = 2'd2,
        ERR_SND_TO  = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_SNT,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        TMR_SND,
        TMR_CAL,
        TMR_MOVE
    } tmr_sel_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timeout_timer.sv
// Shared saturating timeout counter for the send and response waits.
// The expired flag fires on the cycle the count reaches limit-1.
module seq_timeout_timer
    import tour_pkg::*;
#(
    parameter int unsigned SND_TIMEOUT  = 100000,
    parameter int unsigned CAL_TIMEOUT  = 1000000,
    parameter int unsigned MOVE_TIMEOUT = 4000000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear_i,
    input  logic     en_i,
    input  tmr_sel_e sel_i,
    output logic     expired_c_o
);

    localparam int unsigned MAX_T = max3(SND_TIMEOUT, CAL_TIMEOUT, MOVE_TIMEOUT);
    localparam int unsigned TW    = $clog2(MAX_T) + 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [TW-1:0] limit_c;

    always_comb begin
        limit_c = TW'(MOVE_TIMEOUT - 1);
        case (sel_i)
            TMR_SND:  limit_c = TW'(SND_TIMEOUT - 1);
            TMR_CAL:  limit_c = TW'(CAL_TIMEOUT - 1);
            TMR_MOVE: limit_c = TW'(MOVE_TIMEOUT - 1);
            default:  limit_c = TW'(MOVE_TIMEOUT - 1);
        endcase
    end

    // Saturate at all-ones rather than wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c_o = en_i && (cnt_q >= limit_c);

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Plays a stored list of Knight commands to RemoteComm, one at a time,
// waiting for ACK after each and stopping with a coded error on NAK/timeout.
module tour_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CAL_TIMEOUT  = 1000000,
    parameter int unsigned MOVE_TIMEOUT = 4000000,
    parameter int unsigned SND_TIMEOUT  = 100000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [15:0]                wr_data_i,
    input  logic [$clog2(DEPTH):0]     num_cmds_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic [15:0]                cmd_o,
    output logic                       snd_cmd_o,
    input  logic                       cmd_snt_i,
    input  logic                       resp_rdy_i,
    input  logic [7:0]                 resp_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic [$clog2(DEPTH)-1:0]   cur_idx_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    state_e      state_q, state_d;
    knight_cmd_t cmd_q, cmd_d;
    logic        snd_cmd_q, snd_cmd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    err_code_e   err_code_q, err_code_d;
    logic [IW-1:0] cur_idx_q, cur_idx_d;
    logic [CW-1:0] count_q, count_d;

    knight_cmd_t mem_q [DEPTH];

    logic     busy_st_c;
    logic     last_c;
    logic     tmr_en_c;
    logic     tmr_clear_c;
    tmr_sel_e tmr_sel_c;
    logic     tmr_expired_c;

    assign busy_st_c = state_q inside {ST_LOAD, ST_SEND, ST_WAIT_SNT, ST_WAIT_RESP};
    assign last_c    = ({1'b0, cur_idx_q} == (count_q - CW'(1)));

    // Command buffer is writable only while playback is not running.
    always_ff @(posedge clk) begin
        if (wr_en_i && !busy_st_c) begin
            mem_q[wr_addr_i] <= knight_cmd_t'(wr_data_i);
        end
    end

    assign tmr_en_c    = (state_q == ST_WAIT_SNT) || (state_q == ST_WAIT_RESP);
    assign tmr_clear_c = !tmr_en_c || ((state_q == ST_WAIT_SNT) && cmd_snt_i);
    assign tmr_sel_c   = (state_q == ST_WAIT_SNT) ? TMR_SND :
                         (cmd_q.opcode == OP_CAL) ? TMR_CAL : TMR_MOVE;

    seq_timeout_timer #(
        .SND_TIMEOUT  (SND_TIMEOUT),
        .CAL_TIMEOUT  (CAL_TIMEOUT),
        .MOVE_TIMEOUT (MOVE_TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (tmr_clear_c),
        .en_i        (tmr_en_c),
        .sel_i       (tmr_sel_c),
        .expired_c_o (tmr_expired_c)
    );

    // Next state; a response arriving on the timeout cycle takes precedence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = (num_cmds_i == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT_SNT;
            ST_WAIT_SNT: begin
                if (cmd_snt_i) begin
                    state_d = ST_WAIT_RESP;
                end else if (tmr_expired_c) begin
                    state_d = ST_ERR;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_rdy_i) begin
                    if (resp_i == ACK) begin
                        state_d = last_c ? ST_DONE : ST_LOAD;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (tmr_expired_c) begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i && busy_st_c) begin
            state_d = ST_IDLE;
        end
    end

    // Registered outputs derived from the chosen transition.
    always_comb begin
        cmd_d      = cmd_q;
        snd_cmd_d  = (state_d == ST_SEND);
        busy_d     = state_d inside {ST_LOAD, ST_SEND, ST_WAIT_SNT, ST_WAIT_RESP};
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cur_idx_d  = cur_idx_q;
        count_d    = count_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    count_d    = num_cmds_i;
                    cur_idx_d  = '0;
                    done_d     = (num_cmds_i == '0);
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_LOAD: begin
                if (state_d == ST_SEND) begin
                    cmd_d = mem_q[cur_idx_q];
                end
            end
            ST_WAIT_SNT: begin
                if (state_d == ST_ERR) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SND_TO;
                end
            end
            ST_WAIT_RESP: begin
                if (state_d == ST_DONE) begin
                    done_d = 1'b1;
                end else if (state_d == ST_LOAD) begin
                    cur_idx_d = cur_idx_q + IW'(1);
                end else if (state_d == ST_ERR) begin
                    err_d      = 1'b1;
                    err_code_d = resp_rdy_i ? ERR_NAK : ERR_RESP_TO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            snd_cmd_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            cur_idx_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            snd_cmd_q  <= snd_cmd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cur_idx_q  <= cur_idx_d;
            count_q    <= count_d;
        end
    end

    assign cmd_o      = cmd_q;
    assign snd_cmd_o  = snd_cmd_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign cur_idx_o  = cur_idx_q;

endmodule
